socket_arbiter: RTL and testbench
=================================

# socket_arbiter

Round-robin frame arbiter that shares one downstream processing socket between `N_REQ` upstream sockets. When the downstream socket is empty and one or more upstream sockets hold a complete frame, it grants one requester. It then drives that requester's read enable for exactly `MAX_DATA_COUNT` consecutive cycles and presents a select index for the data/dv mux in front of the shared `processing` instance. It is the multi-source counterpart of `socket_controler`.

## Interface
- `N_REQ`, default 4: number of upstream sockets, 1..16.
- `MAX_DATA_COUNT`, default 4: words per frame, the socket size; ≥1.
- `SEL_W`, localparam = max(1, $clog2(N_REQ)): select width.
- `i_clk`  in  1: single clock; all logic on its rising edge.
- `i_rst`  in  1: reset, synchronous and active-high.
- `i_full`  in  N_REQ: bit k high = upstream socket k holds a complete frame.
- `i_empty`  in  1: downstream socket empty, so it can accept a frame.
- `o_rd_en`  out  N_REQ: one-hot read enable to the granted upstream socket.
- `o_sel`  out  SEL_W: index of the last granted requester, used for the data/dv mux.
- `o_busy`  out  1: high while a frame transfer is in progress.
- `o_frame_done`  out  1: single-cycle pulse after the last word of a frame.

## Operation
- FSM states: IDLE, BURST, DONE. All outputs are registered.
- IDLE
  - Grant condition: `i_empty`=1 and `i_full`≠0.
  - On grant: choose the winner by round-robin, register `o_sel`, set the word counter to 0, go to BURST.
- Round-robin
  - Search starts at index `last+1` and wraps modulo `N_REQ`; `last` is the last granted index.
  - `last` updates when the state is entered DONE.
  - Reset sets `last` = `N_REQ`-1, so index 0 has first priority.
- BURST
  - `o_rd_en[o_sel]`=1 and `o_busy`=1; counter increments each cycle, width `$clog2(MAX_DATA_COUNT)+1`.
  - When counter = `MAX_DATA_COUNT`-1: go to DONE.
  - `i_full` and `i_empty` are ignored throughout BURST; a frame is never cut short.
- DONE
  - `o_frame_done`=1, `o_rd_en`=0, `o_busy`=1, then return to IDLE.
  - The idle cycle gives the downstream `i_empty` time to update before the next grant is evaluated.
- `o_sel` holds its value outside BURST.
- Reset values: state IDLE, `o_rd_en`=0, `o_sel`=0, `o_busy`=0, `o_frame_done`=0, counter 0, `last`=`N_REQ`-1.

## Timing
- Grant condition seen in IDLE at cycle t:
  - `o_rd_en` high for cycles t+1 .. t+`MAX_DATA_COUNT`.
  - `o_frame_done` high at cycle t+`MAX_DATA_COUNT`+1.
  - IDLE again at cycle t+`MAX_DATA_COUNT`+2.
- Back-to-back frames: minimum period `MAX_DATA_COUNT`+2 cycles.
- `o_sel` is valid from cycle t+1, aligned with the first `o_rd_en`.
- Simultaneous requests resolve in one cycle with no extra latency.
- `MAX_DATA_COUNT`=1: BURST lasts exactly 1 cycle.
- `N_REQ`=1: always grants index 0 and `o_sel`=0.
- Reset mid-BURST: `o_rd_en` is 0 in the cycle after reset is sampled. The partial frame is abandoned; the system-level reset also flushes the sockets.
- `i_rst` overrides every other input in the same cycle.

## Configuration
- `SOCKET_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, lowest asserted index wins; `last` is not used.
  - Undefined (default): round-robin as described above.
- Timing is identical in both modes.

## Test plan
- Single requester, N_REQ=4, MAX_DATA_COUNT=4, `i_full`=4'b0100, `i_empty`=1 at t:
  - `o_rd_en`=4'b0100 for t+1..t+4, `o_sel`=2.
  - `o_frame_done` pulse at t+5.
- All requesters, `i_full`=4'b1111 held, `i_empty`=1:
  - Grant order 0,1,2,3,0 with a grant every 6 cycles.
  - With `SOCKET_ARB_FIXED_PRIO_EN`: 0,0,0…
- Backpressure, `i_full`=4'b0001, `i_empty`=0 for 10 cycles then 1:
  - No `o_rd_en` while `i_empty`=0.
  - Burst starts the cycle after `i_empty` rises.
- Mid-burst input change: `i_full` drops to 0 and `i_empty` drops to 0 at burst word 2 → all 4 reads still issued, `o_frame_done` still pulses.
- Reset mid-burst: assert `i_rst` at burst word 1 → `o_rd_en`=0, `o_busy`=0 next cycle; the next grant goes to index 0.
- Edge case, MAX_DATA_COUNT=1, N_REQ=1, `i_full`=1 held, `i_empty`=1:
  - `o_rd_en` pulses one cycle every 3 cycles.
  - `o_frame_done` follows each pulse by 1 cycle.

Source files
------------

// File: rtl/socket_arbiter.sv
// ---------------------------------------------------------------------------
// socket_arbiter
//
// Shares one downstream processing socket between N_REQ upstream sockets.
// When the downstream socket is empty and at least one upstream socket holds
// a complete frame, one requester is granted and its read enable is driven
// for exactly MAX_DATA_COUNT consecutive cycles. o_sel steers the data/dv mux
// in front of the shared processing instance.
//
// Build option:
//   SOCKET_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                             undefined -> round-robin starting after the
//                                          last granted index (default)
//
// Parameters:
//   N_REQ           number of upstream sockets (1..16)
//   MAX_DATA_COUNT  words per frame (>= 1)
//   SEL_W           select width, max(1, $clog2(N_REQ)) (derived)
//
// Ports:
//   i_clk         clock, all logic on the rising edge
//   i_rst         synchronous active-high reset
//   i_full        bit k set = upstream socket k holds a complete frame
//   i_empty       downstream socket can accept a frame
//   o_rd_en       one-hot read enable to the granted upstream socket
//   o_sel         index of the last granted requester (mux select)
//   o_busy        high while a frame transfer is in progress
//   o_frame_done  one-cycle pulse after the last word of a frame
// ---------------------------------------------------------------------------
module socket_arbiter #(
    parameter  int N_REQ          = 4,
    parameter  int MAX_DATA_COUNT = 4,
    localparam int SEL_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_full,
    input  logic             i_empty,
    output logic [N_REQ-1:0] o_rd_en,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_busy,
    output logic             o_frame_done
);

    localparam int CNT_W = $clog2(MAX_DATA_COUNT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N_REQ-1:0]   rd_en_q, rd_en_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
`ifndef SOCKET_ARB_FIXED_PRIO_EN
    logic [SEL_W-1:0]   last_q, last_d;
`endif

    logic               found;
    logic [SEL_W-1:0]   winner;

    // Winner selection. Round-robin is done as two priority passes: first the
    // requesters above the last grant, then everything from index 0 up. This
    // wraps modulo N_REQ without needing a variable-index rotate.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first so no path leaves it unassigned (no inferred latch).
        found  = 1'b0;
        winner = '0;
`ifndef SOCKET_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && i_full[k] && (k > int'(last_q))) begin
                found  = 1'b1;
                winner = SEL_W'(k);
            end
        end
`endif
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && i_full[k]) begin
                found  = 1'b1;
                winner = SEL_W'(k);
            end
        end
    end

    // Next-state and next-output logic. Outputs are derived from the next
    // state so that the registered outputs line up with the state they
    // describe (o_rd_en is high in exactly the BURST cycles).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
`ifndef SOCKET_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_empty && (|i_full)) begin
                    state_d = S_BURST;
                    sel_d   = winner;
                    cnt_d   = '0;
                end
            end
            S_BURST: begin
                // Inputs are deliberately ignored here: a frame is never cut short.
                if (cnt_q == CNT_W'(MAX_DATA_COUNT - 1)) begin
                    state_d = S_DONE;
`ifndef SOCKET_ARB_FIXED_PRIO_EN
                    last_d  = sel_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // One turnaround cycle lets the downstream empty flag settle
                // before the next grant is evaluated.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d      = (state_d == S_BURST) ? (N_REQ'(1) << sel_d) : '0;
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sel_q        <= '0;
            rd_en_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifndef SOCKET_ARB_FIXED_PRIO_EN
            // Highest index as "last" gives index 0 first priority.
            last_q       <= SEL_W'(N_REQ - 1);
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            rd_en_q      <= rd_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifndef SOCKET_ARB_FIXED_PRIO_EN
            last_q       <= last_d;
`endif
        end
    end

    assign o_rd_en      = rd_en_q;
    assign o_sel        = sel_q;
    assign o_busy       = busy_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_socket_arbiter.sv
// ---------------------------------------------------------------------------
// tb_socket_arbiter
//
// Self-checking bench for socket_arbiter. Instance dut uses the default
// configuration (N_REQ=4, MAX_DATA_COUNT=4); instance dut_b uses N_REQ=1,
// MAX_DATA_COUNT=1. Expected frames (owner, first cycle, word count) are
// queued when stimulus is applied; a negedge monitor pops and compares them
// as frames appear on o_rd_en.
// ---------------------------------------------------------------------------
module tb_socket_arbiter;

    localparam int N = 4;
    localparam int M = 4;

    typedef struct {
        int sel;
        int start;
        int words;
    } frame_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] full;
    logic         empty;
    logic [N-1:0] rd_en;
    logic [1:0]   sel;
    logic         busy;
    logic         frame_done;

    logic         full_b;
    logic         empty_b;
    logic         rd_b;
    logic         sel_b;
    logic         busy_b;
    logic         done_b;

    int           cyc;
    int           checks;
    int           errors;
    bit           mon_en;
    frame_t       sb[$];

    socket_arbiter #(.N_REQ(N), .MAX_DATA_COUNT(M)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_full       (full),
        .i_empty      (empty),
        .o_rd_en      (rd_en),
        .o_sel        (sel),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    socket_arbiter #(.N_REQ(1), .MAX_DATA_COUNT(1)) dut_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_full       (full_b),
        .i_empty      (empty_b),
        .o_rd_en      (rd_b),
        .o_sel        (sel_b),
        .o_busy       (busy_b),
        .o_frame_done (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        full    = '0;
        empty   = 1'b0;
        full_b  = 1'b0;
        empty_b = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic expect_frame(input int s, input int start, input int words);
        frame_t f;
        f.sel   = s;
        f.start = start;
        f.words = words;
        sb.push_back(f);
    endtask

    // Frame monitor: compares each observed frame against the queue head.
    bit     in_frame;
    frame_t cur;
    int     words_seen;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_en != '0) begin
                if (!in_frame) begin
                    in_frame   = 1'b1;
                    words_seen = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_frame", rd_en, 0);
                        cur.sel   = 0;
                        cur.start = cyc;
                        cur.words = 0;
                    end else begin
                        cur = sb[0];
                        check("frame_start", cyc, cur.start);
                    end
                end
                words_seen++;
                check("rd_onehot", rd_en, 32'd1 << cur.sel);
                check("sel", sel, cur.sel);
                check("busy_burst", busy, 1);
                check("done_in_burst", frame_done, 0);
            end else if (in_frame) begin
                in_frame = 1'b0;
                check("frame_words", words_seen, cur.words);
                check("frame_done", frame_done, (cur.words == M) ? 1 : 0);
                check("busy_after", busy, (cur.words == M) ? 1 : 0);
                if (sb.size() > 0) void'(sb.pop_front());
            end else begin
                check("done_idle", frame_done, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        checks   = 0;
        errors   = 0;
        mon_en   = 1'b0;
        in_frame = 1'b0;

        // ---- reset values ----
        do_reset();
        mon_en = 1'b1;
        check("rst_rd_en", rd_en, 0);
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_b_rd", rd_b, 0);
        check("rst_b_sel", sel_b, 0);

        // ---- single requester ----
        full  = 4'b0100;
        empty = 1'b1;
        expect_frame(2, cyc + 1, M);
        step();
        full = '0;
        wait_idle();
        step();
        check("sel_hold", sel, 2);
        check("idle_rd", rd_en, 0);

        // ---- all requesters held, from reset ----
        do_reset();
        full  = 4'b1111;
        empty = 1'b1;
        t = cyc;
        for (int k = 0; k < 5; k++) begin
`ifdef SOCKET_ARB_FIXED_PRIO_EN
            expect_frame(0, t + 1 + 6 * k, M);
`else
            expect_frame(k % N, t + 1 + 6 * k, M);
`endif
        end
        repeat (25) step();
        full = '0;
        wait_idle();
        step();

        // ---- backpressure ----
        full  = 4'b0001;
        empty = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_rd", rd_en, 0);
        end
        empty = 1'b1;
        expect_frame(0, cyc + 1, M);
        step();
        full = '0;
        wait_idle();
        step();

        // ---- inputs drop mid-burst (last grant was 0, so 1 wins either mode) ----
        full  = 4'b1010;
        empty = 1'b1;
        expect_frame(1, cyc + 1, M);
        step();
        step();
        step();
        full  = '0;
        empty = 1'b0;
        wait_idle();
        step();
        empty = 1'b1;

        // ---- reset mid-burst ----
        full = 4'b1000;
        expect_frame(3, cyc + 1, 2);
        step();
        step();
        full = '0;
        rst  = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_rd", rd_en, 0);
        check("rst_mid_busy", busy, 0);
        // After reset index 0 has first priority again.
        full = 4'b1001;
        expect_frame(0, cyc + 1, M);
        step();
        full = '0;
        wait_idle();
        step();

        // ---- N_REQ=1, MAX_DATA_COUNT=1 ----
        full_b  = 1'b1;
        empty_b = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            check("b_rd", rd_b, ((i - 1) % 3 == 0) ? 1 : 0);
            check("b_done", done_b, (i >= 2 && (i - 2) % 3 == 0) ? 1 : 0);
            check("b_sel", sel_b, 0);
        end
        full_b = 1'b0;

        repeat (4) step();
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
